// File: rtl/trace_filter_scheduler.sv
// Trace record scheduler: buffers kept commits, injects RESYNC/OVERFLOW records, one valid/ready output.
// Optional: define TRACE_SCHED_TIMESTAMP_EN to add a 32-bit cycle timestamp to every record (out_timestamp).
module trace_filter_scheduler #(
   parameter int FIFO_DEPTH               = 8,
   parameter int RESYNC_PERIOD            = 1024,
   parameter int PC_WIDTH                 = 64,
   parameter int LOST_CNT_WIDTH           = 16,
   parameter int RISC_V_INSTRUCTION_WIDTH = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,
   input  logic                                pc_valid,
   input  logic [PC_WIDTH-1:0]                 pc,
   input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] next_instr,
   input  logic                                drop_instr,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [1:0]                          out_kind,
   output logic [PC_WIDTH-1:0]                 out_pc,
   output logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_data,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
   output logic                                overflow_pending
`ifdef TRACE_SCHED_TIMESTAMP_EN
   ,
   output logic [31:0]                         out_timestamp
`endif
);

   // state   | meaning
   // ST_RUN  | output presents the FIFO head (if any)
   // ST_OVF  | output presents the snapshotted OVERFLOW record

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(RESYNC_PERIOD);
   localparam int IW = RISC_V_INSTRUCTION_WIDTH;

   localparam logic [1:0] KIND_INSTR  = 2'd0;
   localparam logic [1:0] KIND_RESYNC = 2'd1;
   localparam logic [1:0] KIND_OVF    = 2'd2;

   typedef enum logic {ST_RUN, ST_OVF} state_t;

   state_t state_q, state_d;

   logic [TW-1:0]             rs_timer;
   logic                      resync_due;
   logic                      commit, cand;

   logic                      stg_valid;
   logic [1:0]                stg_kind;
   logic [PC_WIDTH-1:0]       stg_pc;
   logic [IW-1:0]             stg_data;

   logic [1:0]                mem_kind [FIFO_DEPTH];
   logic [PC_WIDTH-1:0]       mem_pc   [FIFO_DEPTH];
   logic [IW-1:0]             mem_data [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [LW-1:0]             level;
   logic                      push, pop, loss;

   logic [LOST_CNT_WIDTH-1:0] lost_cnt, rec_cnt;
   logic [PC_WIDTH-1:0]       lost_pc, rec_pc;
   logic                      ovf_pend;
   logic                      ovf_enter, ovf_hs;

   assign commit = pc_valid && enable;
   assign cand   = commit && (!drop_instr || resync_due);

   // Terminal count re-arms the timer so the RESYNC commit itself is the first of the next period.
   always_ff @(posedge clk) begin
      if (rst) begin
         rs_timer   <= '0;
         resync_due <= 1'b0;
      end else if (commit) begin
         if (rs_timer == TW'(RESYNC_PERIOD - 1)) begin
            rs_timer   <= '0;
            resync_due <= 1'b1;
         end else begin
            rs_timer   <= rs_timer + 1'b1;
            resync_due <= 1'b0;
         end
      end
   end

   // One-record staging register: gives the fixed one-cycle commit-to-output latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid <= 1'b0;
         stg_kind  <= KIND_INSTR;
         stg_pc    <= '0;
         stg_data  <= '0;
      end else begin
         stg_valid <= cand;
         if (cand) begin
            stg_kind <= resync_due ? KIND_RESYNC : KIND_INSTR;
            stg_pc   <= pc;
            stg_data <= next_instr;
         end
      end
   end

   assign pop  = (state_q == ST_RUN) && (level != '0) && out_ready;
   assign push = stg_valid && ((level < LW'(FIFO_DEPTH)) || pop);
   assign loss = stg_valid && !push;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_kind[wr_ptr] <= stg_kind;
         mem_pc[wr_ptr]   <= stg_pc;
         mem_data[wr_ptr] <= stg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign ovf_enter = (state_q == ST_RUN) && ovf_pend && (level == '0);
   assign ovf_hs    = (state_q == ST_OVF) && out_ready;

   // The OVF record is snapshotted on entry so it stays stable; losses during OVF restart the live counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         lost_cnt <= '0;
         lost_pc  <= '0;
         rec_cnt  <= '0;
         rec_pc   <= '0;
         ovf_pend <= 1'b0;
      end else begin
         if (ovf_enter) begin
            rec_cnt  <= lost_cnt;
            rec_pc   <= lost_pc;
            lost_cnt <= '0;
         end else if (loss) begin
            if (lost_cnt == '0) lost_pc <= stg_pc;
            if (lost_cnt != '1) lost_cnt <= lost_cnt + 1'b1;
         end
         if (loss)        ovf_pend <= 1'b1;
         else if (ovf_hs) ovf_pend <= (lost_cnt != '0);
      end
   end

`ifdef TRACE_SCHED_TIMESTAMP_EN
   logic [31:0] cyc_cnt, lost_ts, rec_ts;
   logic [31:0] mem_ts [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (push) mem_ts[wr_ptr] <= cyc_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt <= '0;
         lost_ts <= '0;
         rec_ts  <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 1'b1;
         if (ovf_enter)                     rec_ts  <= lost_ts;
         else if (loss && lost_cnt == '0)   lost_ts <= cyc_cnt;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      out_kind  = KIND_INSTR;
      out_pc    = '0;
      out_data  = '0;
`ifdef TRACE_SCHED_TIMESTAMP_EN
      out_timestamp = '0;
`endif
      case (state_q)
         ST_RUN: begin
            if (ovf_enter) state_d = ST_OVF;
            if (level != '0) begin
               out_valid = 1'b1;
               out_kind  = mem_kind[rd_ptr];
               out_pc    = mem_pc[rd_ptr];
               out_data  = mem_data[rd_ptr];
`ifdef TRACE_SCHED_TIMESTAMP_EN
               out_timestamp = mem_ts[rd_ptr];
`endif
            end
         end
         ST_OVF: begin
            out_valid = 1'b1;
            out_kind  = KIND_OVF;
            out_pc    = rec_pc;
            out_data  = IW'(rec_cnt);
`ifdef TRACE_SCHED_TIMESTAMP_EN
            out_timestamp = rec_ts;
`endif
            if (out_ready) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign fifo_level       = level;
   assign overflow_pending = ovf_pend;

endmodule

// File: tb/tb_trace_filter_scheduler.sv
// Scoreboard bench for trace_filter_scheduler: main instance (RESYNC_PERIOD 1024) plus a
// second instance with RESYNC_PERIOD 4 for resync insertion.
module tb_trace_filter_scheduler;

   typedef struct packed {
      logic [1:0]  kind;
      logic [63:0] pc;
      logic [31:0] data;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        enable = 1'b1, pc_valid = 1'b0, drop_instr = 1'b0, out_ready = 1'b0;
   logic [63:0] pc = '0;
   logic [31:0] next_instr = '0;
   logic        out_valid, overflow_pending;
   logic [1:0]  out_kind;
   logic [63:0] out_pc;
   logic [31:0] out_data;
   logic [3:0]  fifo_level;

   logic        rs_enable = 1'b1, rs_pc_valid = 1'b0, rs_drop = 1'b0, rs_ready = 1'b1;
   logic [63:0] rs_pc = '0;
   logic [31:0] rs_instr = '0;
   logic        rs_out_valid, rs_ovf_pend;
   logic [1:0]  rs_out_kind;
   logic [63:0] rs_out_pc;
   logic [31:0] rs_out_data;
   logic [3:0]  rs_level;
`ifdef TRACE_SCHED_TIMESTAMP_EN
   logic [31:0] ts_main, ts_rs;
`endif

   trace_filter_scheduler #(.FIFO_DEPTH(8), .RESYNC_PERIOD(1024), .PC_WIDTH(64),
                            .LOST_CNT_WIDTH(16), .RISC_V_INSTRUCTION_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pc_valid(pc_valid), .pc(pc),
      .next_instr(next_instr), .drop_instr(drop_instr), .out_valid(out_valid),
      .out_ready(out_ready), .out_kind(out_kind), .out_pc(out_pc), .out_data(out_data),
      .fifo_level(fifo_level), .overflow_pending(overflow_pending)
`ifdef TRACE_SCHED_TIMESTAMP_EN
      , .out_timestamp(ts_main)
`endif
   );

   trace_filter_scheduler #(.FIFO_DEPTH(8), .RESYNC_PERIOD(4), .PC_WIDTH(64),
                            .LOST_CNT_WIDTH(16), .RISC_V_INSTRUCTION_WIDTH(32)) dut_rs (
      .clk(clk), .rst(rst), .enable(rs_enable), .pc_valid(rs_pc_valid), .pc(rs_pc),
      .next_instr(rs_instr), .drop_instr(rs_drop), .out_valid(rs_out_valid),
      .out_ready(rs_ready), .out_kind(rs_out_kind), .out_pc(rs_out_pc), .out_data(rs_out_data),
      .fifo_level(rs_level), .overflow_pending(rs_ovf_pend)
`ifdef TRACE_SCHED_TIMESTAMP_EN
      , .out_timestamp(ts_rs)
`endif
   );

   rec_t exp_q[$];
   rec_t exp_rs[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic rec_t mk(input logic [1:0] k, input logic [63:0] p, input logic [31:0] d);
      rec_t r;
      r.kind = k;
      r.pc   = p;
      r.data = d;
      return r;
   endfunction

   function automatic logic [31:0] instr_of(input logic [63:0] p);
      return {p[15:0], 16'h0013};
   endfunction

   // Main monitor: pops on every handshake and checks the hold rule between samples.
   logic        prev_hold = 1'b0;
   logic [1:0]  prev_kind;
   logic [63:0] prev_pc;
   logic [31:0] prev_data;
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_kind", out_kind, prev_kind);
            check("hold_pc", out_pc, prev_pc);
            check("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_record kind=%0d pc=%0h data=%0h required=none", out_kind, out_pc, out_data);
            end else begin
               rec_t e;
               e = exp_q.pop_front();
               check("rec_kind", out_kind, e.kind);
               check("rec_pc", out_pc, e.pc);
               check("rec_data", out_data, e.data);
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_kind = out_kind;
         prev_pc   = out_pc;
         prev_data = out_data;
      end else begin
         prev_hold = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst && rs_out_valid && rs_ready) begin
         if (exp_rs.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rs_unexpected_record kind=%0d pc=%0h required=none", rs_out_kind, rs_out_pc);
         end else begin
            rec_t e;
            e = exp_rs.pop_front();
            check("rs_kind", rs_out_kind, e.kind);
            check("rs_pc", rs_out_pc, e.pc);
            check("rs_data", rs_out_data, e.data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pc_valid   = 1'b0;
      drop_instr = 1'b0;
   endtask

   // keep = 0 marks a commit the bench knows will be lost to overflow.
   task automatic drive(input logic [63:0] p, input logic d, input logic keep);
      pc_valid   = 1'b1;
      pc         = p;
      next_instr = instr_of(p);
      drop_instr = d;
      if (!d && keep && enable) exp_q.push_back(mk(2'd0, p, instr_of(p)));
   endtask

   task automatic do_reset();
      idle();
      out_ready = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string nm, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
      check(nm, exp_q.size(), 0);
   endtask

   initial begin
      step();
      step();
      check("rst_valid", out_valid, 0);
      check("rst_kind", out_kind, 0);
      check("rst_pc", out_pc, 0);
      check("rst_data", out_data, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ovf", overflow_pending, 0);
      rst = 1'b0;

      // five kept commits back to back, one-cycle latency
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (i < 5) drive(64'h1000 + 64'(4 * i), 1'b0, 1'b1);
         else       idle();
         @(negedge clk);
         if (i >= 2) begin
            check("lat_valid", out_valid, 1);
            check("lat_pc", out_pc, 64'h1000 + 64'(4 * (i - 2)));
            check("lat_level", fifo_level, 1);
         end
      end
      step();
      wait_drain("drain_basic", 10);

      // RESYNC_PERIOD=4 instance: all dropped, resync on commits 5, 9, 13
      for (int k = 1; k <= 13; k++) begin
         step();
         rs_pc_valid = 1'b1;
         rs_drop     = 1'b1;
         rs_pc       = 64'h2000 + 64'(4 * k);
         rs_instr    = instr_of(rs_pc);
         if (k == 5 || k == 9 || k == 13) exp_rs.push_back(mk(2'd1, rs_pc, rs_instr));
      end
      step();
      rs_pc_valid = 1'b0;
      rs_drop     = 1'b0;
      for (int i = 0; i < 10 && exp_rs.size() != 0; i++) step();
      check("rs_drain", exp_rs.size(), 0);

      // enable low: nothing accepted
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         drive(64'h3000 + 64'(4 * k), 1'b0, 1'b1);
      end
      step();
      idle();
      step();
      step();
      check("dis_level", fifo_level, 0);
      check("dis_valid", out_valid, 0);
      enable = 1'b1;

      // overflow: 11 kept commits into a stalled depth-8 FIFO
      do_reset();
      for (int k = 0; k < 11; k++) begin
         step();
         drive(64'h100 + 64'(4 * k), 1'b0, k < 8);
      end
      step();
      idle();
      step();
      step();
      check("ovf_level", fifo_level, 8);
      check("ovf_pending", overflow_pending, 1);
      check("ovf_head_pc", out_pc, 64'h100);
      exp_q.push_back(mk(2'd2, 64'h120, 32'd3));
      out_ready = 1'b1;
      wait_drain("drain_ovf", 30);
      step();
      check("ovf_cleared", overflow_pending, 0);
      check("ovf_after_valid", out_valid, 0);

      // full FIFO: push and pop on the same edge
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step();
         drive(64'h300 + 64'(4 * k), 1'b0, 1'b1);
      end
      step();
      drive(64'h400, 1'b0, 1'b1);
      step();
      idle();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("full_pp_level", fifo_level, 8);
      check("full_pp_ovf", overflow_pending, 0);
      out_ready = 1'b1;
      wait_drain("drain_full", 20);
      check("full_pp_ovf_end", overflow_pending, 0);

      // hold rule: ready toggles every cycle, sparse random commits
      do_reset();
      for (int i = 0; i < 40; i++) begin
         step();
         out_ready = i[0];
         if ($urandom_range(0, 2) == 0) drive(64'h6000 + 64'(4 * i), ($urandom_range(0, 3) == 0), 1'b1);
         else                           idle();
      end
      step();
      idle();
      out_ready = 1'b1;
      wait_drain("drain_hold", 30);
      check("hold_no_loss", overflow_pending, 0);

      // reset in the middle of a drain with a pending overflow
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step();
         drive(64'h700 + 64'(4 * k), 1'b0, k < 3);
      end
      step();
      idle();
      step();
      step();
      out_ready = 1'b1;
      step();
      step();
      step();
      out_ready = 1'b0;
      check("mid_level", fifo_level, 5);
      check("mid_ovf", overflow_pending, 1);
      check("mid_q", exp_q.size(), 0);
      rst = 1'b1;
      exp_q.delete();
      step();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_ovf", overflow_pending, 0);
      rst = 1'b0;
      drive(64'h800, 1'b0, 1'b1);
      step();
      idle();
      out_ready = 1'b1;
      wait_drain("drain_post_rst", 10);
      step();
      check("post_rst_ovf", overflow_pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
